// File: rtl/fifo_rd_streamer_if.sv
// FIFO read port plus outgoing valid/ready stream for fifo_rd_streamer.
// master = streamer side, slave = FIFO/downstream side.
interface fifo_rd_streamer_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  EMPTY;
   logic                  R_INC;
   logic [DATA_WIDTH-1:0] Rd_data;
   logic [DATA_WIDTH-1:0] OUT_DATA;
   logic                  OUT_VALID;
   logic                  OUT_READY;
   logic                  OUT_LAST;

   modport master (
      input  EMPTY, Rd_data, OUT_READY,
      output R_INC, OUT_DATA, OUT_VALID, OUT_LAST
   );

   modport slave (
      output EMPTY, Rd_data, OUT_READY,
      input  R_INC, OUT_DATA, OUT_VALID, OUT_LAST
   );
endinterface

// File: rtl/fifo_rd_streamer.sv
// Read-domain FIFO consumer: pops into a 2-entry skid buffer and streams words
// out over valid/ready, flagging every BURST_LEN-th accepted word and counting accepts.
module fifo_rd_streamer #(
   parameter int DATA_WIDTH = 8,
   parameter int BURST_LEN  = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 ENABLE,
   fifo_rd_streamer_if.master   bus,
   output logic [CNT_WIDTH-1:0] WORD_CNT,
   output logic                 BUSY
);

   localparam int                BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      DRAIN
   } state_e;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] buf_q [2];
   logic [DATA_WIDTH-1:0] buf_d [2];
   logic [1:0]            occ_q, occ_d;
   logic [BEAT_W-1:0]     beat_q, beat_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  push;
   logic                  accept;
   logic                  valid;
   logic                  wr_idx;

   // Pop decision sees only registered occupancy, never OUT_READY.
   assign valid  = (occ_q != 2'd0);
   assign push   = ENABLE & ~bus.EMPTY & (occ_q < 2'd2) & ~RST;
   assign accept = valid & bus.OUT_READY;
   assign wr_idx = occ_q[0] & ~accept;

   always_comb begin
      buf_d  = buf_q;
      occ_d  = occ_q + {1'b0, push} - {1'b0, accept};
      beat_d = beat_q;
      cnt_d  = cnt_q;
      if (accept) begin
         buf_d[0] = buf_q[1];
         cnt_d    = cnt_q + 1'b1;
         beat_d   = (beat_q == BEAT_LAST) ? '0 : beat_q + 1'b1;
      end
      if (push) begin
         buf_d[wr_idx] = bus.Rd_data;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         buf_q[0] <= '0;
         buf_q[1] <= '0;
         occ_q    <= '0;
         beat_q   <= '0;
         cnt_q    <= '0;
      end else begin
         buf_q[0] <= buf_d[0];
         buf_q[1] <= buf_d[1];
         occ_q    <= occ_d;
         beat_q   <= beat_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (ENABLE) state_d = ACTIVE;
         end
         ACTIVE: begin
            if (!ENABLE) state_d = (occ_d != 2'd0) ? DRAIN : IDLE;
         end
         DRAIN: begin
            if (ENABLE)               state_d = ACTIVE;
            else if (occ_d == 2'd0)   state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.R_INC     = push;
      bus.OUT_VALID = valid;
      bus.OUT_DATA  = buf_q[0];
      bus.OUT_LAST  = valid & (beat_q == BEAT_LAST);
      WORD_CNT      = cnt_q;
      BUSY          = (state_q != IDLE);
   end

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Directed bench for fifo_rd_streamer: a queue models the FIFO, each scenario
// task drives stimulus and checks hand-computed expectations inline.
module tb_fifo_rd_streamer;

   logic       clk;
   logic       rst;
   logic       enable;
   logic [3:0] word_cnt0;
   logic [15:0] word_cnt1;
   logic       busy0, busy1;
   logic       force_empty;
   logic [7:0] fq [$];
   int         errors = 0;
   int         checks = 0;

   fifo_rd_streamer_if #(.DATA_WIDTH(8)) bus0 ();
   fifo_rd_streamer_if #(.DATA_WIDTH(8)) bus1 ();

   assign bus1.EMPTY     = bus0.EMPTY;
   assign bus1.Rd_data   = bus0.Rd_data;
   assign bus1.OUT_READY = bus0.OUT_READY;

   fifo_rd_streamer #(.DATA_WIDTH(8), .BURST_LEN(4), .CNT_WIDTH(4)) u0 (
      .CLK(clk), .RST(rst), .ENABLE(enable), .bus(bus0), .WORD_CNT(word_cnt0), .BUSY(busy0)
   );

   fifo_rd_streamer #(.DATA_WIDTH(8), .BURST_LEN(1), .CNT_WIDTH(16)) u1 (
      .CLK(clk), .RST(rst), .ENABLE(enable), .bus(bus1), .WORD_CNT(word_cnt1), .BUSY(busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog");
   end

   task automatic drive_fifo();
      bus0.EMPTY   = force_empty || (fq.size() == 0);
      bus0.Rd_data = (fq.size() != 0) ? fq[0] : 8'h00;
   endtask

   // One clock: sample pop/accept just before the edge, update FIFO model after it.
   task automatic step(output logic popped, output logic accepted, output logic [7:0] acc_data);
      #1;
      popped   = bus0.R_INC;
      accepted = bus0.OUT_VALID & bus0.OUT_READY;
      acc_data = bus0.OUT_DATA;
      @(posedge clk);
      #1;
      if (popped) void'(fq.pop_front());
      drive_fifo();
      #1;
   endtask

   task automatic do_reset();
      logic p, a;
      logic [7:0] d;
      rst = 1'b1; enable = 1'b0; bus0.OUT_READY = 1'b0; force_empty = 1'b0;
      fq.delete(); drive_fifo();
      step(p, a, d);
      rst = 1'b0;
      step(p, a, d);
   endtask

   task automatic test_reset();
      logic p, a;
      logic [7:0] d;
      rst = 1'b1; enable = 1'b1; bus0.OUT_READY = 1'b1;
      fq.delete(); fq.push_back(8'hAA); drive_fifo();
      for (int i = 0; i < 2; i++) begin
         step(p, a, d);
         checks++; if (p !== 1'b0) begin errors++; $display("FAIL rst_rinc: got %b want 0", p); end
         checks++; if (bus0.OUT_VALID !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus0.OUT_VALID); end
         checks++; if (word_cnt0 !== 4'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", word_cnt0); end
         checks++; if (bus0.OUT_DATA !== 8'h00) begin errors++; $display("FAIL rst_data: got %0h want 00", bus0.OUT_DATA); end
         checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy0); end
      end
      enable = 1'b0; rst = 1'b0;
      fq.delete(); drive_fifo();
      step(p, a, d);
   endtask

   task automatic test_streaming();
      logic p, a;
      logic [7:0] d;
      enable = 1'b1; bus0.OUT_READY = 1'b1;
      for (int i = 0; i < 8; i++) fq.push_back(8'h10 + 8'(i));
      drive_fifo();
      for (int i = 0; i < 8; i++) begin
         step(p, a, d);
         checks++; if (p !== 1'b1) begin errors++; $display("FAIL stream_rinc[%0d]: got %b want 1", i, p); end
         checks++; if (bus0.OUT_VALID !== 1'b1 || bus0.OUT_DATA !== 8'h10 + 8'(i))
            begin errors++; $display("FAIL stream_data[%0d]: got v=%b %0h want v=1 %0h", i, bus0.OUT_VALID, bus0.OUT_DATA, 8'h10 + 8'(i)); end
         checks++; if (bus0.OUT_LAST !== ((i % 4) == 3))
            begin errors++; $display("FAIL stream_last[%0d]: got %b want %b", i, bus0.OUT_LAST, (i % 4) == 3); end
         checks++; if (bus1.OUT_LAST !== 1'b1) begin errors++; $display("FAIL burst1_last[%0d]: got %b want 1", i, bus1.OUT_LAST); end
         checks++; if (word_cnt0 !== 4'(i)) begin errors++; $display("FAIL stream_cnt[%0d]: got %0d want %0d", i, word_cnt0, i); end
      end
      step(p, a, d);
      checks++; if (p !== 1'b0 || a !== 1'b1) begin errors++; $display("FAIL stream_tail: got pop=%b acc=%b want pop=0 acc=1", p, a); end
      checks++; if (bus0.OUT_VALID !== 1'b0) begin errors++; $display("FAIL stream_idle_valid: got %b want 0", bus0.OUT_VALID); end
      checks++; if (word_cnt0 !== 4'd8) begin errors++; $display("FAIL stream_total: got %0d want 8", word_cnt0); end
      checks++; if (word_cnt1 !== 16'd8) begin errors++; $display("FAIL burst1_total: got %0d want 8", word_cnt1); end
      enable = 1'b0;
      step(p, a, d);
      checks++; if (busy0 !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL stream_busy: got %b/%b want 0/0", busy0, busy1); end
   endtask

   task automatic test_backpressure();
      logic p, a;
      logic [7:0] d;
      logic [7:0] exp;
      int pops, n;
      bus0.OUT_READY = 1'b0;
      for (int i = 0; i < 5; i++) fq.push_back(8'h10 + 8'(i));
      drive_fifo();
      enable = 1'b1;
      pops = 0;
      for (int i = 0; i < 6; i++) begin
         step(p, a, d);
         if (p) pops++;
         checks++; if (bus0.OUT_VALID !== 1'b1 || bus0.OUT_DATA !== 8'h10)
            begin errors++; $display("FAIL bp_hold[%0d]: got v=%b %0h want v=1 10", i, bus0.OUT_VALID, bus0.OUT_DATA); end
      end
      checks++; if (pops != 2) begin errors++; $display("FAIL bp_pops: got %0d want 2", pops); end
      checks++; if (fq.size() != 3) begin errors++; $display("FAIL bp_fifo_left: got %0d want 3", fq.size()); end
      checks++; if (bus0.R_INC !== 1'b0) begin errors++; $display("FAIL bp_rinc: got %b want 0", bus0.R_INC); end
      bus0.OUT_READY = 1'b1;
      exp = 8'h10; n = 0;
      for (int k = 0; k < 20 && n < 5; k++) begin
         step(p, a, d);
         if (a) begin
            checks++; if (d !== exp) begin errors++; $display("FAIL bp_order[%0d]: got %0h want %0h", n, d, exp); end
            exp++; n++;
         end
      end
      checks++; if (n != 5) begin errors++; $display("FAIL bp_count: got %0d want 5", n); end
      step(p, a, d);
      checks++; if (bus0.OUT_VALID !== 1'b0 || a !== 1'b0) begin errors++; $display("FAIL bp_dup: got v=%b acc=%b want 0/0", bus0.OUT_VALID, a); end
      checks++; if (word_cnt0 !== 4'd13) begin errors++; $display("FAIL bp_cnt: got %0d want 13", word_cnt0); end
      enable = 1'b0;
      step(p, a, d);
   endtask

   task automatic test_disable_mid_burst();
      logic p, a;
      logic [7:0] d;
      do_reset();
      bus0.OUT_READY = 1'b1;
      for (int i = 0; i < 6; i++) fq.push_back(8'h20 + 8'(i));
      drive_fifo();
      enable = 1'b1;
      step(p, a, d);
      bus0.OUT_READY = 1'b0;
      step(p, a, d);
      bus0.OUT_READY = 1'b1;
      step(p, a, d);
      checks++; if (p !== 1'b0 || a !== 1'b1 || d !== 8'h20)
         begin errors++; $display("FAIL dis_first: got pop=%b acc=%b %0h want 0/1 20", p, a, d); end
      bus0.OUT_READY = 1'b0;
      step(p, a, d);
      checks++; if (bus0.OUT_DATA !== 8'h21 || bus0.R_INC !== 1'b0)
         begin errors++; $display("FAIL dis_full: got %0h rinc=%b want 21 rinc=0", bus0.OUT_DATA, bus0.R_INC); end
      enable = 1'b0;
      step(p, a, d);
      checks++; if (busy0 !== 1'b1 || bus0.OUT_DATA !== 8'h21 || bus0.OUT_LAST !== 1'b0)
         begin errors++; $display("FAIL dis_drain: got busy=%b %0h last=%b want 1 21 0", busy0, bus0.OUT_DATA, bus0.OUT_LAST); end
      bus0.OUT_READY = 1'b1;
      step(p, a, d);
      checks++; if (a !== 1'b1 || d !== 8'h21 || busy0 !== 1'b1 || p !== 1'b0)
         begin errors++; $display("FAIL dis_out1: got acc=%b %0h busy=%b pop=%b want 1 21 1 0", a, d, busy0, p); end
      checks++; if (bus0.OUT_DATA !== 8'h22 || bus0.OUT_LAST !== 1'b0)
         begin errors++; $display("FAIL dis_beat2: got %0h last=%b want 22 0", bus0.OUT_DATA, bus0.OUT_LAST); end
      step(p, a, d);
      checks++; if (a !== 1'b1 || d !== 8'h22 || busy0 !== 1'b0 || bus0.OUT_VALID !== 1'b0)
         begin errors++; $display("FAIL dis_idle: got acc=%b %0h busy=%b v=%b want 1 22 0 0", a, d, busy0, bus0.OUT_VALID); end
      bus0.OUT_READY = 1'b0;
      enable = 1'b1;
      step(p, a, d);
      checks++; if (bus0.OUT_DATA !== 8'h23 || bus0.OUT_LAST !== 1'b1)
         begin errors++; $display("FAIL dis_resume_last: got %0h last=%b want 23 1", bus0.OUT_DATA, bus0.OUT_LAST); end
      checks++; if (word_cnt0 !== 4'd3) begin errors++; $display("FAIL dis_cnt3: got %0d want 3", word_cnt0); end
      bus0.OUT_READY = 1'b1;
      step(p, a, d);
      checks++; if (bus0.OUT_DATA !== 8'h24 || bus0.OUT_LAST !== 1'b0 || word_cnt0 !== 4'd4)
         begin errors++; $display("FAIL dis_newburst: got %0h last=%b cnt=%0d want 24 0 4", bus0.OUT_DATA, bus0.OUT_LAST, word_cnt0); end
      enable = 1'b0;
      step(p, a, d);
      step(p, a, d);
   endtask

   task automatic test_empty_edge();
      logic p, a;
      logic [7:0] d;
      logic [7:0] exp;
      int pops;
      do_reset();
      enable = 1'b1; bus0.OUT_READY = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step(p, a, d);
         checks++; if (p !== 1'b0 || bus0.OUT_VALID !== 1'b0)
            begin errors++; $display("FAIL empty_idle[%0d]: got pop=%b v=%b want 0/0", i, p, bus0.OUT_VALID); end
      end
      fq.push_back(8'h5A); drive_fifo();
      step(p, a, d);
      checks++; if (p !== 1'b1 || bus0.OUT_VALID !== 1'b1 || bus0.OUT_DATA !== 8'h5A || bus0.R_INC !== 1'b0)
         begin errors++; $display("FAIL empty_single: got pop=%b v=%b %0h rinc=%b want 1 1 5a 0", p, bus0.OUT_VALID, bus0.OUT_DATA, bus0.R_INC); end
      step(p, a, d);
      checks++; if (a !== 1'b1 || bus0.OUT_VALID !== 1'b0)
         begin errors++; $display("FAIL empty_after: got acc=%b v=%b want 1 0", a, bus0.OUT_VALID); end
      for (int i = 0; i < 4; i++) fq.push_back(8'h30 + 8'(i));
      pops = 0; exp = 8'h30;
      for (int i = 0; i < 10; i++) begin
         force_empty = (i % 2 == 1) || (i >= 8);
         drive_fifo();
         step(p, a, d);
         if (p) pops++;
         checks++; if (p !== (i % 2 == 0 && i < 8))
            begin errors++; $display("FAIL toggle_pop[%0d]: got %b want %b", i, p, (i % 2 == 0 && i < 8)); end
         if (a) begin
            checks++; if (d !== exp) begin errors++; $display("FAIL toggle_data: got %0h want %0h", d, exp); end
            exp++;
         end
      end
      checks++; if (pops != 4 || exp != 8'h34) begin errors++; $display("FAIL toggle_total: got pops=%0d next=%0h want 4 34", pops, exp); end
      force_empty = 1'b0; enable = 1'b0; drive_fifo();
      step(p, a, d);
   endtask

   task automatic test_counter_wrap();
      logic p, a;
      logic [7:0] d;
      int n;
      do_reset();
      for (int i = 0; i < 17; i++) fq.push_back(8'h40 + 8'(i));
      drive_fifo();
      enable = 1'b1; bus0.OUT_READY = 1'b1;
      n = 0;
      for (int k = 0; k < 40 && n < 17; k++) begin
         step(p, a, d);
         if (a) n++;
      end
      checks++; if (n != 17) begin errors++; $display("FAIL wrap_accepts: got %0d want 17", n); end
      checks++; if (word_cnt0 !== 4'd1) begin errors++; $display("FAIL wrap_cnt: got %0d want 1", word_cnt0); end
      enable = 1'b0;
      step(p, a, d);
      bus0.OUT_READY = 1'b0;
      for (int i = 0; i < 3; i++) fq.push_back(8'h60 + 8'(i));
      drive_fifo();
      enable = 1'b1;
      step(p, a, d);
      step(p, a, d);
      checks++; if (bus0.OUT_VALID !== 1'b1 || bus0.R_INC !== 1'b0)
         begin errors++; $display("FAIL rstmid_full: got v=%b rinc=%b want 1 0", bus0.OUT_VALID, bus0.R_INC); end
      rst = 1'b1;
      #1;
      checks++; if (bus0.R_INC !== 1'b0) begin errors++; $display("FAIL rstmid_rinc: got %b want 0", bus0.R_INC); end
      step(p, a, d);
      checks++; if (bus0.OUT_VALID !== 1'b0 || word_cnt0 !== 4'd0)
         begin errors++; $display("FAIL rstmid_clear: got v=%b cnt=%0d want 0 0", bus0.OUT_VALID, word_cnt0); end
      rst = 1'b0; enable = 1'b0;
      fq.delete(); drive_fifo();
      step(p, a, d);
      checks++; if (bus0.OUT_VALID !== 1'b0 || busy0 !== 1'b0)
         begin errors++; $display("FAIL rstmid_after: got v=%b busy=%b want 0 0", bus0.OUT_VALID, busy0); end
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; force_empty = 1'b0;
      bus0.OUT_READY = 1'b0;
      drive_fifo();
      test_reset();
      test_streaming();
      test_backpressure();
      test_disable_mid_burst();
      test_empty_edge();
      test_counter_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
